// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demux controller: state encoding,
// statistics counter width and the select-width helper.
package stream_demux_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ROUTE = ST_ROUTE,
        S_DROP  = ST_DROP
    } state_e;

    // Width of the destination select; never narrower than one bit.
    function automatic int sel_width(input int n_out);
        return (n_out <= 2) ? 1 : $clog2(n_out);
    endfunction

endpackage

// File: rtl/stream_demux_oreg.sv
// One-entry output register of the stream demux. Holds a beat together
// with the channel it was routed to, so a later header cannot retarget a
// beat that is still waiting for its consumer.
module stream_demux_oreg #(
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_i,
    input  logic [SELW-1:0]  fill_sel_i,
    input  logic [DW-1:0]    fill_data_i,
    input  logic [N_OUT-1:0] m_ready_i,
    output logic             full_o,
    output logic [SELW-1:0]  sel_o,
    output logic [N_OUT-1:0] m_valid_o,
    output logic [DW-1:0]    m_data_o
);

    logic            full_q, full_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [DW-1:0]   data_q, data_d;
    logic            drain;

    // Only the ready bit of the channel holding the beat can drain it.
    assign drain = full_q && m_ready_i[sel_q];

    // Fill and drain in the same cycle reloads the entry, keeping it full.
    always_comb begin
        full_d = fill_i || (full_q && !drain);
        sel_d  = fill_i ? fill_sel_i  : sel_q;
        data_d = fill_i ? fill_data_i : data_q;
    end

    // Entry state; reset clears any pending beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    // Decode the held channel into a one-hot valid vector.
    always_comb begin
        m_valid_o = '0;
        for (int k = 0; k < N_OUT; k++) begin
            m_valid_o[k] = full_q && (sel_q == SELW'(k));
        end
    end

    assign full_o   = full_q;
    assign sel_o    = sel_q;
    assign m_data_o = data_q;

endmodule

// File: rtl/stream_demux_ctrl.sv
// Packet-level controller for a 1:N valid/ready byte-stream demux.
// The first beat of a packet selects the destination channel; the route is
// held until the last beat. Out-of-range selects drop the whole packet and
// raise a one-cycle err_sel pulse.
// Optional statistics counters are enabled by defining
// STREAM_DEMUX_CTRL_STATS_EN.
module stream_demux_ctrl
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int SELW  = sel_width(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic [SELW-1:0]  s_sel,
    input  logic             s_last,
    output logic [N_OUT-1:0] m_valid,
    input  logic [N_OUT-1:0] m_ready,
    output logic [DW-1:0]    m_data,
    output logic             busy,
    output logic             err_sel
`ifdef STREAM_DEMUX_CTRL_STATS_EN
    ,
    output logic [N_OUT*STATS_W-1:0] stats_beats,
    output logic [STATS_W-1:0]       stats_drops
`endif
);

    localparam logic [SELW:0] N_OUT_W = (SELW+1)'(N_OUT);

    state_e          state_q;
    logic [SELW-1:0] lock_sel_q;
    logic            busy_q;
    logic            err_sel_q;

    logic            out_full;
    logic [SELW-1:0] out_sel;
    logic            sel_ok;
    logic            accept;
    logic            fill;
    logic [SELW-1:0] fill_sel;

    // Header selects beyond the last channel (including the unused codes of
    // a non-power-of-two N_OUT) send the packet down the drop path.
    assign sel_ok = {1'b0, s_sel} < N_OUT_W;

    // A dropped packet never touches the output register, so it is never
    // held back; otherwise acceptance follows the pending beat's channel.
    assign s_ready = (state_q == S_DROP) || !out_full || m_ready[out_sel];
    assign accept  = s_valid && s_ready;

    // Decide whether the accepted beat enters the output register and where.
    always_comb begin
        fill     = 1'b0;
        fill_sel = lock_sel_q;
        if (accept) begin
            if (state_q == S_IDLE) begin
                fill     = sel_ok;
                fill_sel = s_sel;
            end else if (state_q == S_ROUTE) begin
                fill     = 1'b1;
            end
        end
    end

    // Packet FSM with registered busy/err_sel outputs and the route latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lock_sel_q <= '0;
            busy_q     <= 1'b0;
            err_sel_q  <= 1'b0;
        end else begin
            err_sel_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (sel_ok) begin
                            lock_sel_q <= s_sel;
                            state_q    <= s_last ? S_IDLE : S_ROUTE;
                        end else begin
                            err_sel_q  <= 1'b1;
                            state_q    <= s_last ? S_IDLE : S_DROP;
                        end
                        busy_q <= !s_last;
                    end
                    S_ROUTE, S_DROP: begin
                        if (s_last) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    stream_demux_oreg #(
        .N_OUT (N_OUT),
        .DW    (DW),
        .SELW  (SELW)
    ) u_oreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill_i      (fill),
        .fill_sel_i  (fill_sel),
        .fill_data_i (s_data),
        .m_ready_i   (m_ready),
        .full_o      (out_full),
        .sel_o       (out_sel),
        .m_valid_o   (m_valid),
        .m_data_o    (m_data)
    );

    assign busy    = busy_q;
    assign err_sel = err_sel_q;

`ifdef STREAM_DEMUX_CTRL_STATS_EN
    logic [STATS_W-1:0] beats_q [N_OUT];
    logic [STATS_W-1:0] drops_q;
    logic [N_OUT-1:0]   hs;

    assign hs = m_valid & m_ready;

    // Free-running wrap-around counters of delivered beats and dropped packets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                beats_q[k] <= '0;
            end
            drops_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (hs[k]) begin
                    beats_q[k] <= beats_q[k] + STATS_W'(1);
                end
            end
            if (err_sel_q) begin
                drops_q <= drops_q + STATS_W'(1);
            end
        end
    end

    // Pack per-channel counters, channel k in bits [16k+15:16k].
    always_comb begin
        stats_beats = '0;
        for (int k = 0; k < N_OUT; k++) begin
            stats_beats[k*STATS_W +: STATS_W] = beats_q[k];
        end
    end

    assign stats_drops = drops_q;
`endif

endmodule

// File: tb/tb_stream_demux_ctrl.sv
// Bench for stream_demux_ctrl: a 4-channel instance driven from a vector
// table, and a 3-channel instance exercised by hand-written drop sequences
// and by random traffic compared against a packet/queue reference model.
module tb_stream_demux_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: N_OUT = 4 ----------------
    logic       rst_na = 1'b0;
    logic       sva = 1'b0;
    logic       sra;
    logic [7:0] da = '0;
    logic [1:0] sela = '0;
    logic       lasta = 1'b0;
    logic [3:0] mva;
    logic [3:0] mra = '0;
    logic [7:0] mda;
    logic       busya, erra;
`ifdef STREAM_DEMUX_CTRL_STATS_EN
    logic [63:0] stb_a;
    logic [15:0] std_a;
`endif

    stream_demux_ctrl #(.N_OUT(4), .DW(8)) u_a (
        .clk(clk), .rst_n(rst_na), .s_valid(sva), .s_ready(sra),
        .s_data(da), .s_sel(sela), .s_last(lasta),
        .m_valid(mva), .m_ready(mra), .m_data(mda),
        .busy(busya), .err_sel(erra)
`ifdef STREAM_DEMUX_CTRL_STATS_EN
        , .stats_beats(stb_a), .stats_drops(std_a)
`endif
    );

    // ---------------- instance B: N_OUT = 3 ----------------
    logic       rst_nb = 1'b0;
    logic       svb = 1'b0;
    logic       srb;
    logic [7:0] db = '0;
    logic [1:0] selb = '0;
    logic       lastb = 1'b0;
    logic [2:0] mvb;
    logic [2:0] mrb = '0;
    logic [7:0] mdb;
    logic       busyb, errb;
`ifdef STREAM_DEMUX_CTRL_STATS_EN
    logic [47:0] stb_b;
    logic [15:0] std_b;
`endif

    stream_demux_ctrl #(.N_OUT(3), .DW(8)) u_b (
        .clk(clk), .rst_n(rst_nb), .s_valid(svb), .s_ready(srb),
        .s_data(db), .s_sel(selb), .s_last(lastb),
        .m_valid(mvb), .m_ready(mrb), .m_data(mdb),
        .busy(busyb), .err_sel(errb)
`ifdef STREAM_DEMUX_CTRL_STATS_EN
        , .stats_beats(stb_b), .stats_drops(std_b)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic       last;
        logic [3:0] mr;
        logic       sr;
        logic [3:0] mv;
        logic [7:0] md;
        logic       dchk;
        logic       busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                                input logic [7:0] d, input logic l, input logic [3:0] mr,
                                input logic sr, input logic [3:0] mv, input logic [7:0] md,
                                input logic dc, input logic b);
        vec_t t;
        t.rst = r; t.v = v; t.sel = s; t.d = d; t.last = l; t.mr = mr;
        t.sr = sr; t.mv = mv; t.md = md; t.dchk = dc; t.busy = b;
        return t;
    endfunction

    // Reference model for instance B: whole packets and an ordered queue of
    // beats owed to the consumers.
    typedef struct {
        int         ch;
        logic [7:0] d;
    } beat_t;

    beat_t q[$];
    bit    in_pkt;
    bit    drop_pkt;
    int    pkt_ch;
    bit    err_exp;
    int    drops_m;
    int    beats_m[3];

    initial begin
        vec_t tbl[$];
        logic       exp_sr;
        logic [2:0] exp_mv;
        beat_t      b;

        // reset / idle
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,1,0));
        // 3-beat packet to ch2, s_sel changed on later beats
        tbl.push_back(mk(1,1,2,8'h11,0,4'hF, 1,4'b0000,8'h00,0,0));
        tbl.push_back(mk(1,1,0,8'h22,0,4'hF, 1,4'b0100,8'h11,1,1));
        tbl.push_back(mk(1,1,3,8'h33,1,4'hF, 1,4'b0100,8'h22,1,1));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0100,8'h33,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,0,0));
        // backpressure on ch1 for 5 cycles, other ready bits high
        tbl.push_back(mk(1,1,1,8'h41,0,4'hF, 1,4'b0000,8'h00,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,1,0,8'h42,1,4'b1101, 0,4'b0010,8'h41,1,1));
        tbl.push_back(mk(1,1,0,8'h42,1,4'hF, 1,4'b0010,8'h41,1,1));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0010,8'h42,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,0,0));
        // back-to-back: single beat to ch0, then 2 beats to ch3
        tbl.push_back(mk(1,1,0,8'hAA,1,4'hF, 1,4'b0000,8'h00,0,0));
        tbl.push_back(mk(1,1,3,8'hBB,0,4'hF, 1,4'b0001,8'hAA,1,0));
        tbl.push_back(mk(1,1,0,8'hCC,1,4'hF, 1,4'b1000,8'hBB,1,1));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b1000,8'hCC,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,0,0));
        // new header to ch0 waits on a pending ch2 beat
        tbl.push_back(mk(1,1,2,8'h51,1,4'hF, 1,4'b0000,8'h00,0,0));
        tbl.push_back(mk(1,1,0,8'h52,1,4'b1011, 0,4'b0100,8'h51,1,0));
        tbl.push_back(mk(1,1,0,8'h52,1,4'hF, 1,4'b0100,8'h51,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0001,8'h52,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,0,0));
        // reset mid-packet with a pending beat (row 25 onward)
        tbl.push_back(mk(1,1,1,8'h61,0,4'h0, 1,4'b0000,8'h00,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0,4'h0, 0,4'b0010,8'h61,1,1));
        tbl.push_back(mk(1,1,0,8'h62,0,4'hF, 1,4'b0000,8'h00,1,0));
        tbl.push_back(mk(1,1,0,8'h63,1,4'hF, 1,4'b0001,8'h62,1,1));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0001,8'h63,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0,4'hF, 1,4'b0000,8'h00,0,0));

        repeat (2) @(posedge clk);
        #1;
        rst_na = 1'b1;
        rst_nb = 1'b1;

        // -------- table-driven run on instance A --------
        for (int i = 0; i < tbl.size(); i++) begin
            rst_na = tbl[i].rst; sva = tbl[i].v; sela = tbl[i].sel;
            da = tbl[i].d; lasta = tbl[i].last; mra = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("row%0d s_ready", i), sra, tbl[i].sr);
            chk($sformatf("row%0d m_valid", i), mva, tbl[i].mv);
            chk($sformatf("row%0d busy", i), busya, tbl[i].busy);
            chk($sformatf("row%0d err_sel", i), erra, 1'b0);
            if (tbl[i].dchk)
                chk($sformatf("row%0d m_data", i), mda, tbl[i].md);
`ifdef STREAM_DEMUX_CTRL_STATS_EN
            if (i == 25)
                chk("stats_beats before reset", stb_a, {16'd2, 16'd4, 16'd2, 16'd2});
            if (i == 27) begin
                chk("stats_beats after reset", stb_a, 64'd0);
                chk("stats_drops after reset", std_a, 16'd0);
            end
`endif
            @(posedge clk);
            #1;
        end
        sva = 1'b0;

        // -------- instance B: out-of-range header drops the packet --------
        svb = 1'b1; selb = 2'd3; db = 8'h71; lastb = 1'b0; mrb = 3'b000;
        @(negedge clk);
        chk("drop hdr s_ready", srb, 1'b1);
        @(posedge clk); #1;
        db = 8'h72; lastb = 1'b1; selb = 2'd0;
        @(negedge clk);
        chk("drop err_sel pulse", errb, 1'b1);
        chk("drop busy", busyb, 1'b1);
        chk("drop s_ready", srb, 1'b1);
        chk("drop m_valid", mvb, 3'b000);
        @(posedge clk); #1;
        svb = 1'b0; lastb = 1'b0;
        @(negedge clk);
        chk("drop err_sel end", errb, 1'b0);
        chk("drop busy end", busyb, 1'b0);
        chk("drop m_valid end", mvb, 3'b000);
`ifdef STREAM_DEMUX_CTRL_STATS_EN
        chk("stats_drops", std_b, 16'd1);
`endif
        @(posedge clk); #1;
        svb = 1'b1; selb = 2'd1; db = 8'h73; lastb = 1'b1; mrb = 3'b111;
        @(negedge clk);
        chk("after drop s_ready", srb, 1'b1);
        @(posedge clk); #1;
        svb = 1'b0;
        @(negedge clk);
        chk("after drop m_valid", mvb, 3'b010);
        chk("after drop m_data", mdb, 8'h73);
        chk("after drop err_sel", errb, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after drop idle", mvb, 3'b000);

        // -------- instance B: random traffic vs reference model --------
        @(posedge clk); #1;
        rst_nb = 1'b0;
        @(posedge clk); #1;
        rst_nb = 1'b1;
        in_pkt = 0; drop_pkt = 0; pkt_ch = 0; err_exp = 0; drops_m = 0;
        for (int k = 0; k < 3; k++) beats_m[k] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            svb   = ($urandom_range(0, 3) != 0);
            selb  = 2'($urandom_range(0, 3));
            db    = 8'($urandom);
            lastb = ($urandom_range(0, 3) == 0);
            mrb   = 3'($urandom);
            if (cyc >= 2980) begin
                svb = 1'b0;
                mrb = 3'b111;
            end
            @(negedge clk);
            exp_sr = (in_pkt && drop_pkt) ? 1'b1
                   : ((q.size() == 0) ? 1'b1 : mrb[q[0].ch]);
            exp_mv = (q.size() != 0) ? 3'(1 << q[0].ch) : 3'b000;
            chk($sformatf("rnd%0d s_ready", cyc), srb, exp_sr);
            chk($sformatf("rnd%0d m_valid", cyc), mvb, exp_mv);
            chk($sformatf("rnd%0d busy", cyc), busyb, in_pkt);
            chk($sformatf("rnd%0d err_sel", cyc), errb, err_exp);
            if (q.size() != 0)
                chk($sformatf("rnd%0d m_data", cyc), mdb, q[0].d);
`ifdef STREAM_DEMUX_CTRL_STATS_EN
            chk($sformatf("rnd%0d stats_drops", cyc), std_b, 16'(drops_m));
            chk($sformatf("rnd%0d stats_beats", cyc), stb_b,
                {16'(beats_m[2]), 16'(beats_m[1]), 16'(beats_m[0])});
`endif
            // consumer side
            if (q.size() != 0 && mrb[q[0].ch]) begin
                beats_m[q[0].ch]++;
                void'(q.pop_front());
            end
            if (err_exp) drops_m++;
            err_exp = 0;
            // producer side
            if (svb && exp_sr) begin
                if (!in_pkt) begin
                    if (selb < 2'd3) begin
                        drop_pkt = 0;
                        pkt_ch = int'(selb);
                        b.ch = pkt_ch; b.d = db;
                        q.push_back(b);
                    end else begin
                        drop_pkt = 1;
                        err_exp = 1;
                    end
                    in_pkt = !lastb;
                end else begin
                    if (!drop_pkt) begin
                        b.ch = pkt_ch; b.d = db;
                        q.push_back(b);
                    end
                    if (lastb) in_pkt = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_ctrl.md
Name: stream_demux_ctrl

Overview:
Packet-level controller and router for a 1:N demultiplexer on a valid/ready byte stream. It latches a destination select on the first beat of each packet and holds that route until the packet's last beat. Beats are steered through a single registered output stage to one of N_OUT consumer channels. It sits between a single upstream source and the per-channel consumers, replacing direct software control of the demux select line.

Parameters:
N_OUT, 4, number of output channels (2..16)
DW, 8, data width in bits
SELW, $clog2(N_OUT) (minimum 1), width of the destination select field

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream beat accepted when s_valid && s_ready
s_data  input  DW  upstream data
s_sel  input  SELW  destination; sampled only on the first beat of a packet
s_last  input  1  marks the final beat of a packet
m_valid  output  N_OUT  one-hot per-channel valid; at most one bit set
m_ready  input  N_OUT  per-channel ready
m_data  output  DW  shared output data bus, qualified by m_valid
busy  output  1  high while a packet is open (state ROUTE or DROP)
err_sel  output  1  one-cycle pulse when a header beat carries s_sel >= N_OUT

Behaviour:
- Clock and reset: all state changes on the rising edge of clk. rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE; lock_sel = 0; out_full = 0.
  - m_valid = 0; m_data = 0; busy = 0; err_sel = 0.
  - s_ready = 1 from the first cycle after reset.
- FSM states: IDLE, ROUTE, DROP.
- IDLE, on a handshake:
  - s_sel < N_OUT: lock_sel <= s_sel, load the beat into the output register, go to ROUTE. If s_last is also set, stay in IDLE (single-beat packet).
  - s_sel >= N_OUT: pulse err_sel, discard the beat, go to DROP. If s_last is also set, stay in IDLE.
- ROUTE:
  - Each handshake loads the beat for channel lock_sel.
  - s_sel is ignored.
  - A handshake with s_last returns to IDLE.
- DROP:
  - s_ready = 1 unconditionally; beats are consumed and discarded.
  - A handshake with s_last returns to IDLE.
- Output register (one-entry pipeline):
  - Latency is 1 cycle from the input handshake to m_valid.
  - m_valid[k] = out_full && (out_sel == k). out_sel is captured with each beat so that a new packet cannot retarget a pending beat.
  - m_data is stable while m_valid is asserted and m_ready is low.
- s_ready in IDLE/ROUTE = !out_full || m_ready[out_sel].
- Simultaneous drain and fill: when the output drains and a new beat is accepted in the same cycle, the register reloads and out_full stays 1. Full throughput is 1 beat/cycle.
- Back-to-back packets: a new header is accepted in the cycle after the previous s_last handshake. A header may target a different channel while the previous beat is still pending; it waits because s_ready follows the pending out_sel.
- Non-power-of-2 N_OUT: s_sel values N_OUT..2^SELW-1 take the DROP path.
- Reset mid-packet: the open packet and any pending output beat are discarded. The next accepted beat is treated as a header.
- m_ready bits for channels other than out_sel have no effect.

Optional Feature:
Macro: STREAM_DEMUX_CTRL_STATS_EN.
- Defined:
  - Adds output stats_beats (N_OUT*16): per-channel 16-bit counters, incremented on each m_valid && m_ready handshake. Channel k occupies bits [16k+15:16k].
  - Adds output stats_drops (16): counts err_sel pulses.
  - All counters reset to 0, wrap from 0xFFFF to 0, and have no saturation.
- Undefined: these ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package stream_demux_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ROUTE=2'd1, ST_DROP=2'd2;
  - STATS_W=16;
  - a function computing SELW from N_OUT.
- One sub-module, stream_demux_oreg: the one-entry output register holding out_full, out_sel and data, with its fill/drain logic. The FSM and select-latch logic stay in stream_demux_ctrl.

Test Plan:
1. Reset then idle → m_valid=0, busy=0, s_ready=1, err_sel=0.
2. N_OUT=4, 3-beat packet, s_sel=2 on the header, data 0x11/0x22/0x33, m_ready all 1 → m_valid=4'b0100 with m_data 0x11/0x22/0x33 on consecutive cycles, 1-cycle latency; busy falls after the last handshake. Changing s_sel on beats 2–3 has no effect.
3. Backpressure: m_ready[1]=0 for 5 cycles during a packet to channel 1 → s_ready=0 and m_data held stable; after release, no beat is lost or duplicated.
4. Back-to-back packets: single-beat packet to ch0 (0xAA), then a 2-beat packet to ch3 (0xBB, 0xCC) with no gap → m_valid=0001 then 1000, 1000 in order, sustaining 1 beat/cycle.
5. N_OUT=3, header s_sel=3, 2 beats → err_sel pulses once, m_valid stays 0, s_ready=1. The next packet to ch1 routes normally. With STATS_EN, stats_drops=1.
6. rst_n low for 1 cycle mid-packet with an output beat pending → m_valid=0 next cycle. The following beat with s_sel=0 is treated as a header and routed to ch0. With STATS_EN, all counters return to 0.
